// File: rtl/fusion_pkg.sv
// rtl/fusion_pkg.sv - shared ALU opcodes, flag indices and writeback entry types
package fusion_pkg;

  localparam int WB_DEPTH = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;

  // One bit per opcode: 2, 3, 13, 14 and 15 are reserved
  localparam logic [15:0] RESERVED_OPS = 16'hE00C;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_PAR   = 2;
  localparam int FLAG_NEG   = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        flag_en;
  } wb_entry_t;

  function automatic logic op_reserved(input logic [3:0] op);
    return RESERVED_OPS[op];
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - ALU result, register-file write and forwarding signals
interface alu_writeback_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry;
  logic        in_overflow;
  logic        in_parity;
  logic        in_neg;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic        in_flag_en;

  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [3:0]  flags_q;

  logic [4:0]  q_rd;
  logic        q_hit;
  logic [31:0] q_data;

  modport slave (
    input  in_valid, in_result, in_carry, in_overflow, in_parity, in_neg,
           in_op, in_rd, in_flag_en, wb_ready, q_rd,
    output in_ready, wb_valid, wb_we, wb_rd, wb_data, flags_q, q_hit, q_data
  );

  modport master (
    output in_valid, in_result, in_carry, in_overflow, in_parity, in_neg,
           in_op, in_rd, in_flag_en, wb_ready, q_rd,
    input  in_ready, wb_valid, wb_we, wb_rd, wb_data, flags_q, q_hit, q_data
  );

endinterface

// File: rtl/alu_wb_fifo.sv
// rtl/alu_wb_fifo.sv - 2-entry in-order buffer with 1-bit wrapping pointers
module alu_wb_fifo
  import fusion_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  wb_entry_t   push_entry,
  input  logic        pop,
  output occ_t        occ,
  output logic        not_full,
  output wb_entry_t   head,
  output logic [31:0] second_result,
  output logic [3:0]  second_op,
  output logic [4:0]  second_rd
);

  wb_entry_t mem [WB_DEPTH];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      push_ok;
  logic      pop_ok;
  occ_t      occ_next;

  assign push_ok = push && not_full;
  assign pop_ok  = pop && (occ != OCC_EMPTY);

  always_comb begin
    occ_next = occ;
    case ({push_ok, pop_ok})
      2'b10:   occ_next = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_next = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= OCC_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      not_full <= 1'b1;
    end else begin
      occ      <= occ_next;
      not_full <= (occ_next != OCC_FULL);
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
    end
  end

  // Payload is only meaningful under a valid occupancy, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign head          = mem[rd_ptr];
  assign second_result = mem[~rd_ptr].result;
  assign second_op     = mem[~rd_ptr].op;
  assign second_rd     = mem[~rd_ptr].rd;

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback buffer with flags register and operand forwarding
module alu_writeback
  import fusion_pkg::*;
(
  input logic            clk,
  input logic            rst,
  alu_writeback_if.slave bus
);

  wb_entry_t   in_entry;
  wb_entry_t   head;
  logic [31:0] second_result;
  logic [3:0]  second_op;
  logic [4:0]  second_rd;
  occ_t        occ;
  logic        not_full;
  logic        head_valid;
  logic        second_valid;
  logic        push;
  logic        pop;
  logic        head_match;
  logic        second_match;
  logic [3:0]  flags;

  assign in_entry = '{
    result:  bus.in_result,
    flags:   {bus.in_neg, bus.in_parity, bus.in_overflow, bus.in_carry},
    op:      bus.in_op,
    rd:      bus.in_rd,
    flag_en: bus.in_flag_en
  };

  assign push = bus.in_valid && not_full;
  assign pop  = head_valid && bus.wb_ready;

  alu_wb_fifo u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_entry    (in_entry),
    .pop           (pop),
    .occ           (occ),
    .not_full      (not_full),
    .head          (head),
    .second_result (second_result),
    .second_op     (second_op),
    .second_rd     (second_rd)
  );

  assign head_valid   = (occ != OCC_EMPTY);
  assign second_valid = (occ == OCC_FULL);

  assign bus.in_ready = not_full;
  assign bus.wb_valid = head_valid;
  assign bus.wb_rd    = head_valid ? head.rd : 5'd0;
  assign bus.wb_data  = head_valid ? head.result : 32'd0;
  assign bus.wb_we    = head_valid && (head.rd != 5'd0) && !op_reserved(head.op);

  // Carry is architecturally defined only by ADD/SUB; other ops leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (pop && head.flag_en) begin
      flags[FLAG_NEG] <= head.flags[FLAG_NEG];
      flags[FLAG_PAR] <= head.flags[FLAG_PAR];
      flags[FLAG_OVF] <= head.flags[FLAG_OVF];
      if (head.op == OP_ADD || head.op == OP_SUB)
        flags[FLAG_CARRY] <= head.flags[FLAG_CARRY];
    end
  end

  assign bus.flags_q = flags;

  // The second slot is always younger than the head, so it wins on a double match
  always_comb begin
    head_match   = head_valid && (bus.q_rd != 5'd0) && (head.rd == bus.q_rd)
                   && !op_reserved(head.op);
    second_match = second_valid && (bus.q_rd != 5'd0) && (second_rd == bus.q_rd)
                   && !op_reserved(second_op);
    bus.q_hit  = head_match || second_match;
    bus.q_data = 32'd0;
    if (second_match)
      bus.q_data = second_result;
    else if (head_match)
      bus.q_data = head.result;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1) as the upstream handshake from the ALU stage.
REQ-004 The block SHALL have port in_result, input, 32, ALU output value.
REQ-005 The block SHALL have ports in_carry, in_overflow, in_parity and in_neg, each input, 1, ALU flags.
REQ-006 The block SHALL have port in_op, input, 4, ALU opcode of the operation.
REQ-007 The block SHALL have ports in_rd (input, 5, destination register) and in_flag_en (input, 1, update flags register).
REQ-008 The block SHALL have ports wb_valid (output, 1), wb_ready (input, 1), wb_we (output, 1), wb_rd (output, 5) and wb_data (output, 32) as the register-file write port.
REQ-009 The block SHALL have port flags_q, output, 4, architectural flags {neg, parity, overflow, carry}.
REQ-010 The block SHALL have ports q_rd (input, 5), q_hit (output, 1) and q_data (output, 32) as the operand-forwarding lookup.

Function
REQ-011 The block SHALL buffer accepted entries {result, flags, op, rd, flag_en} in a 2-entry in-order FIFO.
REQ-012 The FIFO SHALL have occupancy states EMPTY, ONE and FULL.
REQ-013 The FIFO occupancy SHALL follow these transitions: push only -> +1; pop only -> -1; push and pop together -> unchanged.
REQ-014 in_ready SHALL be a registered signal equal to 1 when occupancy is not FULL.
REQ-015 A push SHALL occur when in_valid && in_ready, including while a pop is occurring in the same cycle.
REQ-016 Latency SHALL be 1 cycle: an entry pushed into EMPTY appears on wb_* in the next cycle.
REQ-017 wb_valid SHALL be 1 when occupancy is not EMPTY, and wb_rd/wb_data SHALL show the oldest entry.
REQ-018 A pop SHALL occur when wb_valid && wb_ready; until then, wb_* SHALL stay stable while wb_valid is held.
REQ-019 wb_we SHALL be 1 only when wb_valid, head rd != 0 and head op is not reserved (2, 3, 13, 14, 15).
REQ-020 Entries with wb_we=0 SHALL still require the handshake to drain.
REQ-021 flags_q SHALL update only on a pop of an entry with flag_en=1.
REQ-022 On such a pop, neg, parity and overflow SHALL always be loaded.
REQ-023 On such a pop, carry SHALL be loaded only for op 0 (ADD) or op 1 (SUB) and SHALL otherwise be held.
REQ-024 q_hit SHALL be 1 when any valid entry has rd == q_rd, q_rd != 0 and a non-reserved op.
REQ-025 When q_hit=1, q_data SHALL be the youngest matching entry's result; when q_hit=0, q_data SHALL be 0.
REQ-026 The forwarding lookup SHALL be combinational.
REQ-027 Pointers SHALL be 1-bit and wrap modulo 2.
REQ-028 in_valid SHALL be ignored when in_ready=0 (no overwrite when FULL).

Reset
REQ-029 On rst=1 at a clock edge, occupancy SHALL become EMPTY, pointers 0, in_ready 1, wb_valid 0 and flags_q 4'b0000.
REQ-030 Reset asserted mid-operation SHALL discard buffered entries without issuing any write.
REQ-031 Reset SHALL take precedence over a simultaneous push or pop.
REQ-032 Entry payload storage SHALL need no reset; wb_data and q_data SHALL read 0 while EMPTY.

Structure
REQ-033 A shared package fusion_pkg SHALL hold the ALU opcode constants (ADD=0 ... CMP=12), the reserved-opcode set, flag bit indices (CARRY=0, OVF=1, PAR=2, NEG=3) and WB_DEPTH=2.
REQ-034 Buffer storage and pointers SHALL be one sub-module, alu_wb_fifo.
REQ-035 Flags logic, wb_we qualification and the forwarding lookup SHALL stay in alu_writeback.

Verification
REQ-036 Single op: push ADD result 0x00000005 rd=3 flag_en=1 carry=1 with wb_ready=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=5; the cycle after the pop, flags_q[0]=1.
REQ-037 Backpressure: wb_ready=0 with 3 pushes offered -> 2 accepted, in_ready=0 after the second, third held; raise wb_ready -> in-order drain, third accepted.
REQ-038 x0/reserved: push rd=0 result 0xFFFFFFFF, then op=13 rd=4 -> both drain with wb_we=0; q_hit=0 for q_rd=0 and for q_rd=4.
REQ-039 Carry hold: pop SUB with carry=1, then AND with carry=0, flag_en=1 -> flags_q[0] stays 1 and neg/parity follow the AND entry.
REQ-040 Forwarding: two entries rd=7 (0x11 older, 0x22 younger) -> q_rd=7 gives q_hit=1, q_data=0x22.
REQ-041 Reset mid-operation: FULL then rst pulse -> wb_valid=0, in_ready=1, flags_q=0, no write.
REQ-042 Simultaneous push/pop at occupancy ONE -> occupancy stays ONE and data order is preserved.
